// File: rtl/bcd_display_scan.sv
// bcd_display_scan: shadow-registered 4-digit 7-segment scanner for the BCD counter chain,
// with leading-zero blanking, ghost blanking between slots and a dash for non-BCD codes.
module bcd_display_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int ACTIVE_LOW  = 1,
    parameter int BLANK_LZ    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] d0,
    input  logic [3:0] d1,
    input  logic [3:0] d2,
    input  logic [3:0] d3,
    input  logic       ovf,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       slot
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic POL = (ACTIVE_LOW != 0);
    localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);
    logic [PW-1:0]   p;
    logic [1:0]      idx;
    logic [3:0][3:0] sd;
    logic            sovf;
    logic            wrap;
    logic            blank;
    logic [3:0]      lz;
    logic [3:0]      an_n;
    logic [6:0]      raw;
    always_comb begin
        wrap  = p == PMAX;
        // lz[k]: shadow digits k..3 are all zero, so digit k would be a leading zero
        lz[3] = sd[3] == 4'd0;
        lz[2] = lz[3] && sd[2] == 4'd0;
        lz[1] = lz[2] && sd[1] == 4'd0;
        lz[0] = 1'b0;
        blank = (BLANK_LZ != 0) && lz[idx];
        an_n  = (p != '0 && !blank) ? 4'b0001 << idx : 4'b0000;
        case (sd[idx])
            4'd0:    raw = 7'h3F;
            4'd1:    raw = 7'h06;
            4'd2:    raw = 7'h5B;
            4'd3:    raw = 7'h4F;
            4'd4:    raw = 7'h66;
            4'd5:    raw = 7'h6D;
            4'd6:    raw = 7'h7D;
            4'd7:    raw = 7'h07;
            4'd8:    raw = 7'h7F;
            4'd9:    raw = 7'h6F;
            default: raw = 7'h40;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p    <= '0;
            idx  <= '0;
            sd   <= '0;
            sovf <= 1'b0;
            slot <= 1'b0;
            seg  <= {7{POL}};
            dp   <= POL;
            an   <= {4{POL}};
        end else begin
            p    <= wrap ? '0 : p + PW'(1);
            idx  <= idx + {1'b0, wrap};
            if (load) begin
                sd   <= {d3, d2, d1, d0};
                sovf <= ovf;
            end
            slot <= wrap;
            seg  <= raw ^ {7{POL}};
            dp   <= (idx == 2'd0 && sovf) ^ POL;
            an   <= an_n ^ {4{POL}};
        end
    end
endmodule

// File: tb/tb_bcd_display_scan.sv
// tb_bcd_display_scan: randomized and directed checks of the display scanner against
// a cycle-count based reference model (REFRESH_DIV=4, active-low, leading-zero blanking).
module tb_bcd_display_scan;
    localparam int R = 4;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [3:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
    logic       ovf = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       slot;
    int n_chk = 0;
    int n_fail = 0;
    // reference state: edges since reset release, shadow digits and overflow
    int   m_k = 0;
    int   m_sh[4] = '{0, 0, 0, 0};
    bit   m_ovf = 1'b0;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_slot, e_segv;
    logic [6:0] seg_tab[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    bcd_display_scan #(.REFRESH_DIV(R), .ACTIVE_LOW(1), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .load(load), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .ovf(ovf), .seg(seg), .dp(dp), .an(an), .slot(slot)
    );

    always #5 clk = ~clk;

    // One clock: expected outputs come from the slot position and shadow before the edge.
    task automatic tick();
        int p, k, hi;
        bit blank;
        @(posedge clk);
        p = m_k % R;
        k = (m_k / R) % 4;
        hi = 0;
        for (int j = k; j < 4; j++) hi += m_sh[j];
        blank  = (k != 0) && (hi == 0);
        e_an   = (p != 0 && !blank) ? ~(4'b0001 << k) : 4'hF;
        e_seg  = ~seg_tab[m_sh[k]];
        e_segv = !blank;
        e_dp   = !(k == 0 && m_ovf);
        e_slot = (p == R - 1);
        if (load) begin
            m_sh  = '{int'(d0), int'(d1), int'(d2), int'(d3)};
            m_ovf = ovf;
        end
        m_k++;
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_k = 0;
        m_sh = '{0, 0, 0, 0};
        m_ovf = 1'b0;
    endtask

    task automatic set_digits(input int a3, input int a2, input int a1, input int a0, input bit o);
        d3 = 4'(a3); d2 = 4'(a2); d1 = 4'(a1); d0 = 4'(a0); ovf = o;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if ({an, seg, dp, slot} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
                n_fail++;
                $display("FAIL reset: an=%h seg=%h dp=%b slot=%b, need an=f seg=7f dp=1 slot=0", an, seg, dp, slot);
            end
        end
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_scan_9675();
        set_digits(9, 6, 7, 5, 0);
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n_chk++;
            if ({an, dp, slot} !== {e_an, e_dp, e_slot} || (e_segv && seg !== e_seg)) begin
                n_fail++;
                $display("FAIL scan_9675 cyc %0d: an=%h seg=%h dp=%b slot=%b, need an=%h seg=%h dp=%b slot=%b",
                         i, an, seg, dp, slot, e_an, e_seg, e_dp, e_slot);
            end
        end
    endtask

    task automatic test_blanking();
        bit hi_lit;
        hi_lit = 1'b0;
        set_digits(0, 0, 4, 2, 0);
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 36; i++) begin
            tick();
            if (an[3] === 1'b0 || an[2] === 1'b0) hi_lit = 1'b1;
            n_chk++;
            if ({an, dp, slot} !== {e_an, e_dp, e_slot} || (e_segv && seg !== e_seg)) begin
                n_fail++;
                $display("FAIL blank_0042 cyc %0d: an=%h seg=%h dp=%b, need an=%h seg=%h dp=%b",
                         i, an, seg, dp, e_an, e_seg, e_dp);
            end
        end
        n_chk++;
        if (hi_lit) begin
            n_fail++;
            $display("FAIL blank_0042_hi: an[3]/an[2] went low, need never low");
        end
        set_digits(0, 0, 0, 0, 0);
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 36; i++) begin
            tick();
            n_chk++;
            if ((an !== 4'hF && an !== 4'b1110) || (an === 4'b1110 && seg !== ~7'h3F) || an !== e_an) begin
                n_fail++;
                $display("FAIL blank_0000 cyc %0d: an=%h seg=%h, need an=%h seg=40", i, an, seg, e_an);
            end
        end
    endtask

    task automatic test_dash_ovf();
        set_digits(0, 0, 4'hC, 0, 1);
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 36; i++) begin
            tick();
            n_chk++;
            if ({an, dp, slot} !== {e_an, e_dp, e_slot} || (e_segv && seg !== e_seg) ||
                (an === 4'b1101 && seg !== ~7'h40) || (an === 4'b1110 && {seg, dp} !== {~7'h3F, 1'b0})) begin
                n_fail++;
                $display("FAIL dash_ovf cyc %0d: an=%h seg=%h dp=%b, need an=%h seg=%h dp=%b",
                         i, an, seg, dp, e_an, e_seg, e_dp);
            end
        end
    endtask

    task automatic test_hold_then_load();
        set_digits(1, 2, 3, 4, 0);
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 32; i++) begin
            set_digits($urandom_range(15), $urandom_range(15), $urandom_range(15), $urandom_range(15), 1'($urandom));
            tick();
            n_chk++;
            if ({an, dp, slot} !== {e_an, e_dp, e_slot} || (e_segv && seg !== e_seg)) begin
                n_fail++;
                $display("FAIL hold cyc %0d: an=%h seg=%h dp=%b, need an=%h seg=%h dp=%b",
                         i, an, seg, dp, e_an, e_seg, e_dp);
            end
        end
        // load exactly on the wrap edge so the new shadow feeds the next slot
        while (m_k % R != R - 1) tick();
        set_digits(8, 0, 5, 3, 1);
        load = 1'b1;
        tick();
        load = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            n_chk++;
            if ({an, dp, slot} !== {e_an, e_dp, e_slot} || (e_segv && seg !== e_seg)) begin
                n_fail++;
                $display("FAIL wrap_load cyc %0d: an=%h seg=%h dp=%b, need an=%h seg=%h dp=%b",
                         i, an, seg, dp, e_an, e_seg, e_dp);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (i < 100) load = 1'b1;
            else load = ($urandom_range(7) == 0);
            set_digits(($urandom_range(3) == 0) ? 0 : $urandom_range(15),
                       ($urandom_range(3) == 0) ? 0 : $urandom_range(15),
                       ($urandom_range(3) == 0) ? 0 : $urandom_range(15),
                       $urandom_range(15), 1'($urandom));
            tick();
            n_chk++;
            if ({an, dp, slot} !== {e_an, e_dp, e_slot} || (e_segv && seg !== e_seg)) begin
                n_fail++;
                $display("FAIL random cyc %0d: an=%h seg=%h dp=%b slot=%b, need an=%h seg=%h dp=%b slot=%b",
                         i, an, seg, dp, slot, e_an, e_seg, e_dp, e_slot);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_mid_reset();
        int wait_cnt;
        set_digits(1, 1, 1, 1, 1);
        load = 1'b1;
        tick();
        load = 1'b0;
        while (m_k % (4 * R) != 2 * R + 2) tick();
        #2 rst = 1'b0;
        #1;
        n_chk++;
        if ({an, seg, dp, slot} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset: an=%h seg=%h dp=%b slot=%b, need an=f seg=7f dp=1 slot=0", an, seg, dp, slot);
        end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        wait_cnt = 0;
        while (wait_cnt < 6) begin
            tick();
            wait_cnt++;
            n_chk++;
            if ({an, dp, slot} !== {e_an, e_dp, e_slot} || slot !== (wait_cnt == R)) begin
                n_fail++;
                $display("FAIL post_reset cyc %0d: an=%h dp=%b slot=%b, need an=%h dp=%b slot=%b",
                         wait_cnt, an, dp, slot, e_an, e_dp, e_slot);
            end
            if (an !== 4'hF) break;
        end
        n_chk++;
        if (an !== 4'b1110) begin
            n_fail++;
            $display("FAIL first_enable: an=%h, need 1110", an);
        end
    endtask

    initial begin
        test_reset();
        test_scan_9675();
        test_blanking();
        test_dash_ovf();
        test_hold_then_load();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
